// File: rtl/img_buf_seq.sv
// img_buf_seq: frame sequencer for the 4-bank interpolation image buffer.
// FILL streams a raster frame into the buffer write port; READ turns map
// coordinates into buffer read addresses and delays the fractional weights
// so they line up with the buffer's lu/ru/ld/rd outputs.
module img_buf_seq #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int FRAC_BITS  = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              in_pixel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              buf_pixel,
  output logic                    buf_w_en,
  output logic [9:0]              buf_wx,
  output logic [9:0]              buf_wy,
  input  logic [10+FRAC_BITS-1:0] crd_x,
  input  logic [10+FRAC_BITS-1:0] crd_y,
  input  logic                    crd_last,
  input  logic                    crd_valid,
  output logic                    crd_ready,
  output logic [9:0]              buf_rx,
  output logic [9:0]              buf_ry,
  output logic                    samp_valid,
  output logic [FRAC_BITS-1:0]    samp_fx,
  output logic [FRAC_BITS-1:0]    samp_fy,
  output logic                    samp_last,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CW = 10 + FRAC_BITS;
  localparam logic [9:0] X_LAST  = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] Y_LAST  = 10'(IMG_HEIGHT - 1);
  localparam logic [9:0] X_CLAMP = 10'(IMG_WIDTH - 2);
  localparam logic [9:0] Y_CLAMP = 10'(IMG_HEIGHT - 2);
  localparam logic [FRAC_BITS-1:0] F_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_READ, S_DRAIN} state_t;

  typedef struct packed {
    logic [FRAC_BITS-1:0] fx;
    logic [FRAC_BITS-1:0] fy;
    logic                 last;
  } samp_t;

  state_t r_state, w_state_nxt;

  logic [9:0] r_cx, r_cy;
  logic [7:0] r_pixel;
  logic       r_w_en;
  logic [9:0] r_wx, r_wy, r_rx, r_ry;
  logic       r_done;

  logic [RD_LATENCY:0] r_vld_pipe;
  samp_t               r_dat_pipe [RD_LATENCY:0];

  logic                 w_pix_hs, w_crd_hs, w_fill_end, w_samp_end;
  logic [9:0]           w_xi, w_yi, w_rx, w_ry;
  logic [FRAC_BITS-1:0] w_fx, w_fy;

  assign w_pix_hs   = in_valid && in_ready;
  assign w_crd_hs   = crd_valid && crd_ready;
  assign w_fill_end = w_pix_hs && (r_cx == X_LAST) && (r_cy == Y_LAST);
  assign w_samp_end = samp_valid && samp_last;

  assign w_xi = crd_x[CW-1:FRAC_BITS];
  assign w_yi = crd_y[CW-1:FRAC_BITS];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: start only counts in IDLE; each phase ends on its last event
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)                  w_state_nxt = S_FILL;
      S_FILL:  if (w_fill_end)             w_state_nxt = S_READ;
      S_READ:  if (w_crd_hs && crd_last)   w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_samp_end)             w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = (r_state == S_FILL);
    crd_ready = (r_state == S_READ);
    busy      = (r_state != S_IDLE);
  end

  // Raster write counters and registered buffer write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_pixel <= '0;
      r_w_en  <= 1'b0;
      r_wx    <= '0;
      r_wy    <= '0;
    end else begin
      r_w_en <= w_pix_hs;
      if (r_state == S_IDLE && start) begin
        r_cx <= '0;
        r_cy <= '0;
      end else if (w_pix_hs) begin
        r_pixel <= in_pixel;
        r_wx    <= r_cx;
        r_wy    <= r_cy;
        if (r_cx == X_LAST) begin
          r_cx <= '0;
          r_cy <= (r_cy == Y_LAST) ? 10'd0 : r_cy + 10'd1;
        end else begin
          r_cx <= r_cx + 10'd1;
        end
      end
    end
  end

  // Split coordinates; clamp so the bilinear 2x2 never leaves the frame
  always_comb begin
    w_rx = w_xi;
    w_fx = crd_x[FRAC_BITS-1:0];
    w_ry = w_yi;
    w_fy = crd_y[FRAC_BITS-1:0];
    if (w_xi >= X_LAST) begin
      w_rx = X_CLAMP;
      w_fx = F_MAX;
    end
    if (w_yi >= Y_LAST) begin
      w_ry = Y_CLAMP;
      w_fy = F_MAX;
    end
  end

  // Registered read address; holds between handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx <= '0;
      r_ry <= '0;
    end else if (w_crd_hs) begin
      r_rx <= w_rx;
      r_ry <= w_ry;
    end
  end

  // Weight alignment pipe: stage 0 matches the address register, the last
  // stage matches the buffer outputs RD_LATENCY cycles later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) r_dat_pipe[i] <= '0;
    end else begin
      r_vld_pipe[0] <= w_crd_hs;
      r_dat_pipe[0] <= '{fx: w_fx, fy: w_fy, last: crd_last && w_crd_hs};
      for (int i = 1; i <= RD_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_dat_pipe[i] <= r_dat_pipe[i-1];
      end
    end
  end

  // End-of-frame pulse, one cycle after the last sample leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (r_state == S_DRAIN) && w_samp_end;
  end

  assign buf_pixel  = r_pixel;
  assign buf_w_en   = r_w_en;
  assign buf_wx     = r_wx;
  assign buf_wy     = r_wy;
  assign buf_rx     = r_rx;
  assign buf_ry     = r_ry;
  assign samp_valid = r_vld_pipe[RD_LATENCY];
  assign samp_fx    = r_dat_pipe[RD_LATENCY].fx;
  assign samp_fy    = r_dat_pipe[RD_LATENCY].fy;
  assign samp_last  = r_dat_pipe[RD_LATENCY].last;
  assign frame_done = r_done;

endmodule

// File: tb/tb_img_buf_seq.sv
// Bench for img_buf_seq: a cycle-level behavioural model (mode, pixel count,
// sample queue keyed by due cycle) checked every cycle, plus literal checks.
module tb_img_buf_seq;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int F  = 4;
  localparam int RL = 2;
  localparam int CW = 10 + F;
  typedef logic [CW-1:0] crd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, in_valid, crd_last, crd_valid;
  logic [7:0]    in_pixel;
  crd_t          crd_x, crd_y;
  logic          in_ready, buf_w_en, crd_ready, samp_valid, samp_last, busy, frame_done;
  logic [7:0]    buf_pixel;
  logic [9:0]    buf_wx, buf_wy, buf_rx, buf_ry;
  logic [F-1:0]  samp_fx, samp_fy;

  always #5 clk = ~clk;

  img_buf_seq #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FRAC_BITS(F), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .buf_pixel(buf_pixel), .buf_w_en(buf_w_en), .buf_wx(buf_wx), .buf_wy(buf_wy),
    .crd_x(crd_x), .crd_y(crd_y), .crd_last(crd_last), .crd_valid(crd_valid),
    .crd_ready(crd_ready), .buf_rx(buf_rx), .buf_ry(buf_ry),
    .samp_valid(samp_valid), .samp_fx(samp_fx), .samp_fy(samp_fy),
    .samp_last(samp_last), .busy(busy), .frame_done(frame_done)
  );

  int n_chk = 0, n_pass = 0;
  int n_we = 0, n_sv = 0, n_fd = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 fill, 2 read, 3 drain
  typedef struct {int due; int fx; int fy; bit last;} smp_t;
  smp_t q[$];
  smp_t s_new, s_out;
  int cyc = 0, m_mode = 0, m_wcount = 0, old_mode = 0;
  bit m_prev_last = 0;
  int e_w_en = 0, e_pix = 0, e_wx = 0, e_wy = 0, e_rx = 0, e_ry = 0;
  int e_sv = 0, e_fx = 0, e_fy = 0, e_last = 0, e_fd = 0;
  int t_i, t_f;

  function automatic void split(input int c, input int lim, output int i, output int f);
    i = c >> F;
    f = c % (1 << F);
    if (i >= lim - 1) begin
      i = lim - 2;
      f = (1 << F) - 1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_wcount = 0; m_prev_last = 0; q.delete();
      e_w_en = 0; e_pix = 0; e_wx = 0; e_wy = 0; e_rx = 0; e_ry = 0;
      e_sv = 0; e_fx = 0; e_fy = 0; e_last = 0; e_fd = 0;
    end else begin
      cyc++;
      old_mode = m_mode;
      e_w_en = 0;
      e_fd = 0;
      if (old_mode == 0 && start) begin
        m_mode = 1;
        m_wcount = 0;
      end
      if (old_mode == 1 && in_valid) begin
        e_w_en = 1;
        e_pix  = in_pixel;
        e_wx   = m_wcount % W;
        e_wy   = m_wcount / W;
        m_wcount++;
        if (m_wcount == W * H) m_mode = 2;
      end
      if (old_mode == 2 && crd_valid) begin
        split(int'(crd_x), W, t_i, t_f); e_rx = t_i; s_new.fx = t_f;
        split(int'(crd_y), H, t_i, t_f); e_ry = t_i; s_new.fy = t_f;
        s_new.due  = cyc + RL;
        s_new.last = crd_last;
        q.push_back(s_new);
        if (crd_last) m_mode = 3;
      end
      if (old_mode == 3 && m_prev_last) begin
        e_fd = 1;
        m_mode = 0;
      end
      e_sv = 0;
      e_last = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        s_out = q.pop_front();
        e_sv = 1; e_fx = s_out.fx; e_fy = s_out.fy; e_last = s_out.last;
      end
      m_prev_last = (e_sv != 0) && (e_last != 0);
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_mode == 1);
    chk("crd_ready", crd_ready, m_mode == 2);
    chk("busy", busy, m_mode != 0);
    chk("buf_w_en", buf_w_en, e_w_en);
    chk("samp_valid", samp_valid, e_sv);
    chk("frame_done", frame_done, e_fd);
    chk("buf_rx", buf_rx, e_rx);
    chk("buf_ry", buf_ry, e_ry);
    if (e_w_en != 0) begin
      chk("buf_pixel", buf_pixel, e_pix);
      chk("buf_wx", buf_wx, e_wx);
      chk("buf_wy", buf_wy, e_wy);
    end
    if (e_sv != 0) begin
      chk("samp_fx", samp_fx, e_fx);
      chk("samp_fy", samp_fy, e_fy);
      chk("samp_last", samp_last, e_last);
    end
    if (buf_w_en)   n_we++;
    if (samp_valid) n_sv++;
    if (frame_done) n_fd++;
  end

  // ---------------- stimulus ----------------
  function automatic crd_t rc();
    return crd_t'($urandom_range(0, (W + 2) << F));
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill(input bit tog);
    int k = 0;
    while (m_mode == 1 && k < 1000) begin
      in_valid = tog ? ((k % 3 == 0) || ($urandom_range(0, 3) == 0)) : 1'b1;
      in_pixel = tog ? 8'($urandom) : 8'(m_wcount);
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    chk("fill_to_read", crd_ready, 1);
  endtask

  task automatic send_crd(input crd_t x, input crd_t y, input bit last);
    crd_x = x; crd_y = y; crd_last = last; crd_valid = 1'b1;
    @(posedge clk); #1;
    crd_valid = 1'b0; crd_last = 1'b0;
  endtask

  task automatic directed(input crd_t x, input crd_t y, input int rx, input int ry,
                          input int fx, input int fy, input string nm);
    crd_x = x; crd_y = y; crd_last = 1'b0; crd_valid = 1'b1;
    @(posedge clk); #1;
    crd_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_rx"}, buf_rx, rx);
    chk({nm, "_ry"}, buf_ry, ry);
    repeat (RL) @(posedge clk);
    @(negedge clk);
    chk({nm, "_sv"}, samp_valid, 1);
    chk({nm, "_fx"}, samp_fx, fx);
    chk({nm, "_fy"}, samp_fy, fy);
    chk({nm, "_last"}, samp_last, 0);
    @(posedge clk); #1;
  endtask

  task automatic read_rand(input int n);
    int sent = 0, k = 0;
    while (sent < n && k < 1000) begin
      if ($urandom_range(0, 2) != 0) begin
        crd_x = rc(); crd_y = rc(); crd_last = (sent == n - 1); crd_valid = 1'b1;
        sent++;
      end else begin
        crd_valid = 1'b0; crd_last = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    crd_valid = 1'b0; crd_last = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (m_mode != 0 && k < lim) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    chk("frame_end_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
    crd_x = '0; crd_y = '0; crd_last = 1'b0; crd_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_crd_ready", crd_ready, 0);
    chk("rst_w_en", buf_w_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_samp_valid", samp_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wx", buf_wx, 0);
    chk("rst_rx", buf_rx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: continuous raster 0..63, directed reads, 4-sample burst
    n_we = 0;
    do_start();
    fill(1'b0);
    @(negedge clk);
    chk("in_ready_after_fill", in_ready, 0);
    chk("crd_ready_after_fill", crd_ready, 1);
    @(posedge clk); #1;
    chk("w_en_count1", n_we, 64);
    directed(crd_t'(14'h38), crd_t'(14'h24), 3, 2, 8, 4, "mid");
    directed(crd_t'(14'h70), crd_t'(14'h95), 6, 6, 15, 15, "clamp");
    n_sv = 0; n_fd = 0;
    for (int i = 0; i < 4; i++) send_crd(rc(), rc(), i == 3);
    @(negedge clk);
    chk("crd_ready_after_last", crd_ready, 0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(20);
    repeat (2) @(posedge clk); #1;
    chk("burst_samp_count", n_sv, 4);
    chk("burst_frame_done", n_fd, 1);
    chk("busy_after_burst", busy, 0);

    // Frame 2: gappy pixel stream, random coordinate stream
    n_we = 0;
    do_start();
    fill(1'b1);
    @(posedge clk); #1;
    chk("w_en_count2", n_we, 64);
    read_rand(12);
    wait_idle(50);

    // Frame 3: reset with two samples in flight
    do_start();
    fill(1'b0);
    send_crd(rc(), rc(), 1'b0);
    send_crd(rc(), rc(), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_samp_valid", samp_valid, 0);
    chk("mid_rst_rx", buf_rx, 0);
    chk("mid_rst_ry", buf_ry, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_crd_ready", crd_ready, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    n_sv = 0; n_fd = 0;
    repeat (4) @(posedge clk); #1;
    chk("mid_rst_no_samples", n_sv, 0);
    chk("mid_rst_no_done", n_fd, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    in_valid = 1'b1; in_pixel = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("restart_w_en", buf_w_en, 1);
    chk("restart_wx", buf_wx, 0);
    chk("restart_wy", buf_wy, 0);
    chk("restart_pixel", buf_pixel, 8'hA5);
    @(posedge clk); #1;
    fill(1'b1);
    read_rand(20);
    wait_idle(60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/img_buf_seq.md
Name: img_buf_seq

Overview:
- Frame sequencer for the 4-bank interpolation image buffer.
- FILL phase: accepts a raster pixel stream and drives the buffer write port (`pixel`/`w_en`/`wx`/`wy`).
- READ phase: accepts fixed-point source coordinates from the rectification map and drives the buffer read port (`rx`/`ry`). Delays the fractional weights so they arrive in the same cycle as the buffer's `lu`/`ru`/`ld`/`rd` outputs, for the bilinear interpolator downstream.

Parameters:
- IMG_WIDTH, 8, frame width in pixels (even, ≥4, ≤1024)
- IMG_HEIGHT, 8, frame height in pixels (even, ≥4, ≤1024)
- FRAC_BITS, 4, fractional bits of map coordinates
- RD_LATENCY, 2, cycles from `rx`/`ry` presented to `lu`/`ru`/`ld`/`rd` valid

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: begin a frame; honoured only in IDLE
- in_pixel  in  8  raster pixel
- in_valid  in  1  in_pixel valid
- in_ready  out  1  pixel accepted when in_valid&&in_ready
- buf_pixel  out  8  to buffer `pixel`
- buf_w_en  out  1  to buffer `w_en`
- buf_wx, buf_wy  out  10 each  to buffer `wx`/`wy`
- crd_x, crd_y  in  10+FRAC_BITS each  unsigned source coordinate, integer.fraction
- crd_last  in  1  marks last coordinate of frame
- crd_valid  in  1  coordinate valid
- crd_ready  out  1  coordinate accepted when crd_valid&&crd_ready
- buf_rx, buf_ry  out  10 each  to buffer `rx`/`ry`
- samp_valid  out  1  buffer outputs valid this cycle
- samp_fx, samp_fy  out  FRAC_BITS each  interpolation weights aligned to buffer outputs
- samp_last  out  1  last sample of frame
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: all outputs 0, state IDLE, pixel counters 0, alignment pipeline valid bits cleared. Buffer contents are not touched.
- States: IDLE, FILL, READ, DRAIN.
- IDLE:
  - in_ready=0, crd_ready=0.
  - start -> FILL, write counters cleared to (0,0).
  - start in any other state is ignored.
- FILL:
  - in_ready=1.
  - On a pixel handshake, the next cycle has buf_w_en=1, buf_pixel=in_pixel, and buf_wx/buf_wy = counter values (registered).
  - With no handshake, buf_w_en=0 next cycle and the counters hold.
  - Counter order: wx increments; at IMG_WIDTH-1, wx wraps to 0 and wy increments.
  - Handshake at (IMG_WIDTH-1, IMG_HEIGHT-1): in_ready=0 from the next cycle; -> READ.
- READ:
  - crd_ready=1 every cycle; throughput is 1 coordinate per cycle.
  - Split: xi = crd_x>>FRAC_BITS, fx = low FRAC_BITS of crd_x; same for y.
  - Clamp: if xi ≥ IMG_WIDTH-1, rx=IMG_WIDTH-2 and fx=2^FRAC_BITS-1. Same rule with IMG_HEIGHT for y. The buffer therefore never receives its right/bottom edge row or column.
  - Handshake at cycle T:
    - buf_rx/buf_ry registered, valid at T+1.
    - samp_valid=1 with matching samp_fx/samp_fy/samp_last at T+1+RD_LATENCY. This is T+3 at the default.
  - buf_rx/buf_ry hold their last value when there is no handshake.
  - Handshake with crd_last=1: crd_ready=0 from T+1; -> DRAIN.
- DRAIN:
  - Waits for the pipeline to emit samp_last.
  - frame_done=1 in the cycle after samp_valid&&samp_last; -> IDLE the same cycle.
- Sample path has no backpressure; the downstream consumer must accept every samp_valid.
- FILL and READ never overlap, so there is no buffer read/write hazard.
- rst_n assertion mid-frame: immediate IDLE; in-flight samples are discarded, with no samp_valid and no frame_done.

Test Plan:
- Reset, start, 64 pixels 0..63 with continuous in_valid (8x8):
  - buf_w_en high for exactly 64 cycles; (wx,wy) runs (0,0),(1,0)…(7,7); buf_pixel matches.
  - in_ready low after the 64th handshake; crd_ready=1 the following cycle.
- FILL with in_valid toggling 1,0,0,1,…:
  - buf_w_en only on cycles after handshakes; no coordinate skipped or repeated; READ is entered only after 64 writes.
- READ, crd_x=0x38 (3.5), crd_y=0x24 (2.25), handshake cycle T:
  - buf_rx=3, buf_ry=2 at T+1.
  - samp_valid=1, samp_fx=8, samp_fy=4 at T+3.
- Clamp, crd_x=0x70 (7.0), crd_y=0x95 (9.3125):
  - buf_rx=6, buf_ry=6, samp_fx=15, samp_fy=15.
- Four back-to-back coordinates, crd_last on the 4th:
  - samp_valid on 4 consecutive cycles, samp_last on the 4th, frame_done next cycle, busy=0 after.
  - crd_ready=0 from the cycle after the last handshake.
  - start during DRAIN ignored.
- rst_n low while 2 samples are in flight:
  - samp_valid and all outputs 0 immediately; no frame_done.
  - Subsequent start restarts FILL at (0,0).
